uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each received character and its parity/stop error flags from the receiver's single-cycle AXI-Stream valid pulse.
- Stores entries in a circular FIFO and presents them on a standard AXI-Stream master interface to the bus/host side.
- Decouples the receiver, which never waits on tready, from a consumer that may stall. Reports overflow when a character arrives with the FIFO full.

Parameters:
- DATA_WIDTH, 8: character width in bits.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH): derived localparam, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- s_axis_tdata_i  in  DATA_WIDTH  received character.
- s_axis_tvalid_i  in  1  character valid, normally a 1-cycle pulse.
- s_axis_tready_o  out  1  FIFO not full; informational, since the source does not stall.
- parity_err_i  in  1  parity error for the character; sampled with s_axis_tvalid_i.
- stop_err_i  in  1  stop-bit error for the character; sampled with s_axis_tvalid_i.
- m_axis_tdata_o  out  DATA_WIDTH  head character.
- m_axis_tuser_o  out  2  head flags, {stop_err, parity_err}.
- m_axis_tvalid_o  out  1  FIFO not empty.
- m_axis_tready_i  in  1  consumer accepts the head entry.
- level_o  out  AW+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a character was dropped because the FIFO was full.
- clear_i  in  1  synchronous flush; also clears overflow_o.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+2) array. wr_ptr and rd_ptr are AW+1 bits and wrap modulo 2*DEPTH.
- Empty: pointers equal. Full: low AW bits equal and MSBs differ.
- level_o = wr_ptr - rd_ptr, computed in AW+1 bits.
- Reset state: pointers 0, overflow_o 0, level_o 0, m_axis_tvalid_o 0, s_axis_tready_o 1. m_axis_tdata_o and m_axis_tuser_o read 0, because the array is reset to 0.
- Reset mid-operation: all contents are discarded immediately and asynchronously.
- Write:
  - Occurs when s_axis_tvalid_i && !full at a clock edge.
  - Stores {stop_err_i, parity_err_i, s_axis_tdata_i} at wr_ptr, then wr_ptr increments.
  - Write only the exact beat; nothing is done with an idle tvalid.
- Full drop:
  - s_axis_tvalid_i while full discards the character and sets overflow_o = 1 on the same edge.
  - Stored contents and pointers are unchanged.
- Read:
  - First-word-fall-through: m_axis_tdata_o and m_axis_tuser_o show mem[rd_ptr] whenever m_axis_tvalid_o = 1.
  - m_axis_tvalid_o = !empty.
  - A handshake (m_axis_tvalid_o && m_axis_tready_i) increments rd_ptr.
- Latency: a character written at edge N appears on m_axis_tvalid_o after edge N, i.e. valid in cycle N+1.
- Output stability: while m_axis_tvalid_o = 1 and m_axis_tready_i = 0, data and user stay stable (AXI-Stream rule).
- Simultaneous write and read:
  - Not full: both occur and level_o is unchanged.
  - Full: fullness is evaluated before the read, so the write is dropped, overflow_o is set, and the read still completes.
  - Empty: no read is possible, so only the write occurs.
- clear_i:
  - Highest priority: both pointers go to 0 and overflow_o goes to 0.
  - A same-cycle write or read is ignored.
- overflow_o: stays 1 until clear_i or reset.
- Pointer wrap: after 2*DEPTH writes, ordering and level stay correct with no special case.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_DROP_EN.
- When defined:
  - A beat with parity_err_i or stop_err_i set is not written.
  - Adds output port err_drop_cnt_o (8 bits), a saturating count at 255 of discarded bad characters.
  - err_drop_cnt_o resets to 0 on rst_n_i and on clear_i.
  - A bad beat arriving while full increments err_drop_cnt_o and does not set overflow_o.
  - m_axis_tuser_o always reads 2'b00.
- When not defined: every beat is stored with its flags, and the err_drop_cnt_o port is absent.

Test Plan:
- Reset, then write 0xA5 with flags 00, m_axis_tready_i = 1 -> m_axis_tvalid_o = 1 in the next cycle with tdata 0xA5, tuser 00; level_o goes 1 then 0.
- m_axis_tready_i = 0, write 16 characters 0x00..0x0F -> level_o = 16, s_axis_tready_o = 0, overflow_o = 0. A 17th write of 0x10 -> overflow_o = 1, level_o stays 16. Draining then returns 0x00..0x0F in order and 0x10 never appears.
- With FIFO full, assert m_axis_tready_i and a write of 0x55 in the same cycle -> 0x00 is read, 0x55 is dropped, overflow_o = 1, level_o = 15.
- Write 0x3C with parity_err_i = 1, then 0x7E with stop_err_i = 1 -> tuser 01 then 10 with macro undefined. With UART_RX_FIFO_ERR_DROP_EN defined: nothing is stored and err_drop_cnt_o = 2.
- Continuous stream of 40 characters with m_axis_tready_i toggling 1/0 each cycle -> all 40 are received in order across pointer wrap, and overflow_o stays 0.
- Level 5 with overflow_o = 1, assert clear_i together with a write of 0x99 -> level_o = 0, overflow_o = 0, m_axis_tvalid_o = 0 in the next cycle, and 0x99 is not stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures received characters with error flags into a FWFT circular FIFO
// and presents them on an AXI-Stream master. Optional macro UART_RX_FIFO_ERR_DROP_EN drops bad beats.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic                  parity_err_i,
    input  logic                  stop_err_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [1:0]            m_axis_tuser_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [AW:0]           level_o,
    output logic                  overflow_o,
`ifdef UART_RX_FIFO_ERR_DROP_EN
    output logic [7:0]            err_drop_cnt_o,
`endif
    input  logic                  clear_i
);

    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 2;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [EW-1:0] wdata, head;
    logic          full, empty, bad, wr_en, rd_en, ovf_set;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

`ifdef UART_RX_FIFO_ERR_DROP_EN
    // Only clean characters are stored, so the stored flag field is always zero.
    assign bad   = parity_err_i | stop_err_i;
    assign wdata = {2'b00, s_axis_tdata_i};
`else
    assign bad   = 1'b0;
    assign wdata = {stop_err_i, parity_err_i, s_axis_tdata_i};
`endif

    // Fullness is judged before any same-cycle read, so a write into a full FIFO always drops.
    assign wr_en   = s_axis_tvalid_i && !full && !bad;
    assign ovf_set = s_axis_tvalid_i && full && !bad;
    assign rd_en   = !empty && m_axis_tready_i;

    // Storage array, cleared asynchronously so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !clear_i) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef UART_RX_FIFO_ERR_DROP_EN
    // Saturating count of characters discarded for parity/stop errors.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_drop_cnt_o <= 8'd0;
        end else if (clear_i) begin
            err_drop_cnt_o <= 8'd0;
        end else if (s_axis_tvalid_i && bad && (err_drop_cnt_o != 8'hFF)) begin
            err_drop_cnt_o <= err_drop_cnt_o + 8'd1;
        end
    end
`endif

    assign head            = mem[rd_idx];
    assign m_axis_tdata_o  = head[DATA_WIDTH-1:0];
    assign m_axis_tuser_o  = head[EW-1:DATA_WIDTH];
    assign m_axis_tvalid_o = !empty;
    assign s_axis_tready_o = !full;
    assign level_o         = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DATA_WIDTH 8, DEPTH 16).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       perr;
    logic       serr;
    logic [7:0] m_tdata;
    logic [1:0] m_tuser;
    logic       m_tvalid;
    logic       m_tready;
    logic [4:0] level;
    logic       ovf;
    logic       clr;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    logic [7:0] err_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] rxq [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .s_axis_tdata_i (s_tdata),
        .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready),
        .parity_err_i   (perr),
        .stop_err_i     (serr),
        .m_axis_tdata_o (m_tdata),
        .m_axis_tuser_o (m_tuser),
        .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready),
        .level_o        (level),
        .overflow_o     (ovf),
`ifdef UART_RX_FIFO_ERR_DROP_EN
        .err_drop_cnt_o (err_cnt),
`endif
        .clear_i        (clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; s_tdata = 8'h00; s_tvalid = 1'b0; perr = 1'b0; serr = 1'b0;
        m_tready = 1'b0; clr = 1'b0;
        #12;
        check("rst_level",   32'(level),    32'd0);
        check("rst_mvalid",  32'(m_tvalid), 32'd0);
        check("rst_sready",  32'(s_tready), 32'd1);
        check("rst_ovf",     32'(ovf),      32'd0);
        check("rst_tdata",   32'(m_tdata),  32'd0);
        check("rst_tuser",   32'(m_tuser),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single character with FWFT latency
        s_tdata = 8'hA5; s_tvalid = 1'b1; m_tready = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check("one_mvalid", 32'(m_tvalid), 32'd1);
        check("one_tdata",  32'(m_tdata),  32'hA5);
        check("one_tuser",  32'(m_tuser),  32'd0);
        check("one_level1", 32'(level),    32'd1);
        tick();
        check("one_level0", 32'(level),    32'd0);
        check("one_empty",  32'(m_tvalid), 32'd0);

        // Fill to full, then overflow
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 8'(i); s_tvalid = 1'b1;
            tick();
        end
        check("full_level",  32'(level),    32'd16);
        check("full_sready", 32'(s_tready), 32'd0);
        check("full_ovf0",   32'(ovf),      32'd0);
        s_tdata = 8'h10;
        tick();
        s_tvalid = 1'b0;
        check("drop_ovf",   32'(ovf),     32'd1);
        check("drop_level", 32'(level),   32'd16);
        check("hold_tdata", 32'(m_tdata), 32'h00);

        // Full with simultaneous read and write: write dropped, read completes
        s_tdata = 8'h55; s_tvalid = 1'b1; m_tready = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check("rw_level", 32'(level), 32'd15);
        check("rw_ovf",   32'(ovf),   32'd1);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(m_tdata), 32'(i));
            tick();
        end
        check("drain_empty", 32'(m_tvalid), 32'd0);
        check("drain_level", 32'(level),    32'd0);
        m_tready = 1'b0;

        // Error flags
        s_tdata = 8'h3C; perr = 1'b1; serr = 1'b0; s_tvalid = 1'b1;
        tick();
        s_tdata = 8'h7E; perr = 1'b0; serr = 1'b1;
        tick();
        s_tvalid = 1'b0; serr = 1'b0;
`ifdef UART_RX_FIFO_ERR_DROP_EN
        check("err_level", 32'(level),   32'd0);
        check("err_cnt",   32'(err_cnt), 32'd2);
`else
        check("err_level", 32'(level),   32'd2);
        check("err_d0",    32'(m_tdata), 32'h3C);
        check("err_u0",    32'(m_tuser), 32'd1);
        m_tready = 1'b1;
        tick();
        check("err_d1",    32'(m_tdata), 32'h7E);
        check("err_u1",    32'(m_tuser), 32'd2);
        tick();
        check("err_empty", 32'(m_tvalid), 32'd0);
        m_tready = 1'b0;
`endif

        // Clear beats a same-cycle write and resets overflow
        for (int i = 0; i < 5; i++) begin
            s_tdata = 8'(8'h21 + i); s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        check("pre_clr_level", 32'(level), 32'd5);
        check("pre_clr_ovf",   32'(ovf),   32'd1);
        s_tdata = 8'h99; s_tvalid = 1'b1; clr = 1'b1;
        tick();
        s_tvalid = 1'b0; clr = 1'b0;
        check("clr_level",  32'(level),    32'd0);
        check("clr_ovf",    32'(ovf),      32'd0);
        check("clr_mvalid", 32'(m_tvalid), 32'd0);
        tick();
        check("clr_nowr",   32'(level),    32'd0);

        // Sparse stream of 40 characters with tready toggling, across pointer wrap
        begin
            int ntx;
            ntx = 0;
            for (int cyc = 0; cyc < 400 && rxq.size() < 40; cyc++) begin
                s_tvalid = (ntx < 40) && ((cyc % 2) == 0);
                s_tdata  = 8'(8'h40 + ntx);
                m_tready = ((cyc % 2) == 1);
                if (m_tvalid && m_tready) rxq.push_back(m_tdata);
                if (s_tvalid) ntx++;
                tick();
            end
            s_tvalid = 1'b0; m_tready = 1'b0;
        end
        check("stream_count", 32'(rxq.size()), 32'd40);
        for (int i = 0; i < rxq.size(); i++) begin
            check($sformatf("stream_%0d", i), 32'(rxq[i]), 32'(8'h40 + i));
        end
        check("stream_ovf",   32'(ovf),   32'd0);
        check("stream_level", 32'(level), 32'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            s_tdata = 8'(8'hC0 + i); s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        check("pre_arst_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_level",  32'(level),    32'd0);
        check("arst_mvalid", 32'(m_tvalid), 32'd0);
        check("arst_tdata",  32'(m_tdata),  32'd0);
        rst_n = 1'b1;
        tick();
        check("arst_sready", 32'(s_tready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
